// File: rtl/lv1_lv2_arb_pkg.sv
// Shared types and defaults for the L1/L2 bus arbiter.
// The proc round-robin option is enabled with LV1_LV2_ARB_ROUND_ROBIN_EN.
package lv1_lv2_arb_pkg;

    localparam int unsigned DefNumCores      = 4;
    localparam int unsigned DefTimeoutCycles = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PROC = 2'b01,
        RESP = 2'b10
    } arb_state_t;

    // $clog2 that never returns a zero width
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/lv1_lv2_prio_pick.sv
// Combinational priority picker: first active request at or above base_i,
// wrapping modulo N. Returns a one-hot grant.
module lv1_lv2_prio_pick
    import lv1_lv2_arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = clog2_min1(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] base_i,
    output logic [N-1:0]    gnt_o,
    output logic            valid_o
);

    always_comb begin
        int unsigned      k;
        logic [IdxW-1:0]  kidx;
        gnt_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        kidx    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(base_i) + i;
            if (k >= N) begin
                k = k - N;
            end
            kidx = IdxW'(k);
            if (!valid_o && req_i[kidx]) begin
                gnt_o[kidx] = 1'b1;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lv1_lv2_arb_param.sv
// L1/L2 bus arbiter: proc tenure with nested snoop/L2 response grants and a
// sticky watchdog. Define LV1_LV2_ARB_ROUND_ROBIN_EN for round-robin proc pick.
module lv1_lv2_arb_param
    import lv1_lv2_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES      = DefNumCores,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CORES-1:0] bus_lv1_lv2_req_proc,
    output logic [NUM_CORES-1:0] bus_lv1_lv2_gnt_proc,
    input  logic [NUM_CORES-1:0] bus_lv1_lv2_req_snoop,
    output logic [NUM_CORES-1:0] bus_lv1_lv2_gnt_snoop,
    input  logic                 bus_lv1_lv2_req_lv2,
    output logic                 bus_lv1_lv2_gnt_lv2,
    output logic [1:0]           arb_state,
    output logic                 arb_timeout
);

    localparam int unsigned IdxW = clog2_min1(NUM_CORES);
    localparam int unsigned CntW = clog2_min1(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    arb_state_t           state_q, state_d;
    logic [NUM_CORES-1:0] proc_pg_q, proc_pg_d;
    logic [NUM_CORES-1:0] snoop_pg_q, snoop_pg_d;
    logic                 lv2_pg_q, lv2_pg_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_CORES-1:0] proc_pick, snoop_pick;
    logic                 proc_pick_vld, snoop_pick_vld;
    logic [IdxW-1:0]      proc_base;
    logic                 proc_held, resp_held;

`ifdef LV1_LV2_ARB_ROUND_ROBIN_EN
    logic [IdxW-1:0] ptr_q, ptr_d;

    assign proc_base = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && proc_pick_vld) begin
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (proc_pick[i]) begin
                    ptr_d = (i == NUM_CORES - 1) ? '0 : IdxW'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign proc_base = '0;
`endif

    lv1_lv2_prio_pick #(
        .N    (NUM_CORES),
        .IdxW (IdxW)
    ) u_proc_pick (
        .req_i   (bus_lv1_lv2_req_proc),
        .base_i  (proc_base),
        .gnt_o   (proc_pick),
        .valid_o (proc_pick_vld)
    );

    // Snoop responses are always fixed priority.
    lv1_lv2_prio_pick #(
        .N    (NUM_CORES),
        .IdxW (IdxW)
    ) u_snoop_pick (
        .req_i   (bus_lv1_lv2_req_snoop),
        .base_i  ('0),
        .gnt_o   (snoop_pick),
        .valid_o (snoop_pick_vld)
    );

    assign proc_held = |(proc_pg_q & bus_lv1_lv2_req_proc);
    assign resp_held = (|(snoop_pg_q & bus_lv1_lv2_req_snoop)) |
                       (lv2_pg_q & bus_lv1_lv2_req_lv2);

    always_comb begin
        state_d    = state_q;
        proc_pg_d  = proc_pg_q;
        snoop_pg_d = snoop_pg_q;
        lv2_pg_d   = lv2_pg_q;
        unique case (state_q)
            IDLE: begin
                proc_pg_d  = '0;
                snoop_pg_d = '0;
                lv2_pg_d   = 1'b0;
                if (proc_pick_vld) begin
                    proc_pg_d = proc_pick;
                    state_d   = PROC;
                end
            end
            PROC: begin
                if (!proc_held) begin
                    proc_pg_d  = '0;
                    snoop_pg_d = '0;
                    lv2_pg_d   = 1'b0;
                    state_d    = IDLE;
                end else if (!(|snoop_pg_q) && !lv2_pg_q) begin
                    if (snoop_pick_vld) begin
                        snoop_pg_d = snoop_pick;
                        state_d    = RESP;
                    end else if (bus_lv1_lv2_req_lv2) begin
                        lv2_pg_d = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            RESP: begin
                // Proc drop ends the whole tenure, even if the response also drops.
                if (!proc_held) begin
                    proc_pg_d  = '0;
                    snoop_pg_d = '0;
                    lv2_pg_d   = 1'b0;
                    state_d    = IDLE;
                end else if (!resp_held) begin
                    snoop_pg_d = '0;
                    lv2_pg_d   = 1'b0;
                    state_d    = PROC;
                end
            end
            default: begin
                proc_pg_d  = '0;
                snoop_pg_d = '0;
                lv2_pg_d   = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // Watchdog: counts tenure cycles, saturates; a zero limit disables it.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
        if (TIMEOUT_CYCLES != 0 && cnt_d == CntMax) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            proc_pg_q  <= '0;
            snoop_pg_q <= '0;
            lv2_pg_q   <= 1'b0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            proc_pg_q  <= proc_pg_d;
            snoop_pg_q <= snoop_pg_d;
            lv2_pg_q   <= lv2_pg_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus_lv1_lv2_gnt_proc  = proc_pg_q & bus_lv1_lv2_req_proc;
    assign bus_lv1_lv2_gnt_snoop = snoop_pg_q & bus_lv1_lv2_req_snoop;
    assign bus_lv1_lv2_gnt_lv2   = lv2_pg_q & bus_lv1_lv2_req_lv2;
    assign arb_state             = state_q;
    assign arb_timeout           = timeout_q;

endmodule

// File: tb/tb_lv1_lv2_arb_param.sv
// Directed bench for lv1_lv2_arb_param: vector table plus hand-written
// sequences for bubble, simultaneous drop, async reset, RR pick and watchdog.
module tb_lv1_lv2_arb_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_proc, gnt_proc, req_snoop, gnt_snoop;
    logic       req_lv2, gnt_lv2;
    logic [1:0] arb_state;
    logic       arb_timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] p;
        logic [3:0] s;
        logic       l;
        logic [3:0] gp;
        logic [3:0] gs;
        logic       gl;
        logic [1:0] st;
        logic       to;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    lv1_lv2_arb_param #(
        .NUM_CORES      (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .bus_lv1_lv2_req_proc  (req_proc),
        .bus_lv1_lv2_gnt_proc  (gnt_proc),
        .bus_lv1_lv2_req_snoop (req_snoop),
        .bus_lv1_lv2_gnt_snoop (gnt_snoop),
        .bus_lv1_lv2_req_lv2   (req_lv2),
        .bus_lv1_lv2_gnt_lv2   (gnt_lv2),
        .arb_state             (arb_state),
        .arb_timeout           (arb_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full tenure from IDLE: request, check grant, drop, back to IDLE.
    task automatic tenure(input logic [3:0] req, input logic [3:0] exp, input string name);
        req_proc  = req;
        req_snoop = 4'b0000;
        req_lv2   = 1'b0;
        cyc();
        chk({name, "_gnt"}, 32'(gnt_proc), 32'(exp));
        chk({name, "_state"}, 32'(arb_state), 32'(2'b01));
        req_proc = 4'b0000;
        cyc();
        chk({name, "_idle"}, 32'(arb_state), 32'(2'b00));
    endtask

    initial begin
        //             p        s        l     gp       gs       gl    st     to
        vecs[0]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0};
        vecs[1]  = '{4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0};
        vecs[2]  = '{4'b0110, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'b01, 1'b0};
        vecs[3]  = '{4'b0110, 4'b1000, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'b01, 1'b0};
        vecs[4]  = '{4'b0110, 4'b1000, 1'b1, 4'b0010, 4'b1000, 1'b0, 2'b10, 1'b0};
        vecs[5]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'b10, 1'b0};
        vecs[6]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'b01, 1'b0};
        vecs[7]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b1, 2'b10, 1'b0};
        vecs[8]  = '{4'b0110, 4'b0100, 1'b1, 4'b0010, 4'b0000, 1'b1, 2'b10, 1'b0};
        vecs[9]  = '{4'b0100, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'b10, 1'b0};
        vecs[10] = '{4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'b00, 1'b1};
        vecs[11] = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'b01, 1'b1};

        // Reset with all requests high: grants must still read zero.
        rst_n     = 1'b0;
        req_proc  = 4'b1111;
        req_snoop = 4'b1111;
        req_lv2   = 1'b1;
        #3;
        chk("rst_gnt_proc", 32'(gnt_proc), 32'(0));
        chk("rst_gnt_snoop", 32'(gnt_snoop), 32'(0));
        chk("rst_gnt_lv2", 32'(gnt_lv2), 32'(0));
        chk("rst_state", 32'(arb_state), 32'(0));
        chk("rst_timeout", 32'(arb_timeout), 32'(0));
        req_proc  = 4'b0000;
        req_snoop = 4'b0000;
        req_lv2   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 12; i++) begin
            req_proc  = vecs[i].p;
            req_snoop = vecs[i].s;
            req_lv2   = vecs[i].l;
            @(negedge clk);
            chk($sformatf("v%0d_gnt_proc", i), 32'(gnt_proc), 32'(vecs[i].gp));
            chk($sformatf("v%0d_gnt_snoop", i), 32'(gnt_snoop), 32'(vecs[i].gs));
            chk($sformatf("v%0d_gnt_lv2", i), 32'(gnt_lv2), 32'(vecs[i].gl));
            chk($sformatf("v%0d_state", i), 32'(arb_state), 32'(vecs[i].st));
            chk($sformatf("v%0d_timeout", i), 32'(arb_timeout), 32'(vecs[i].to));
            @(posedge clk);
            #1;
        end

        // Proc and snoop drop together in RESP, then one-cycle bubble.
        req_snoop = 4'b0001;
        cyc();
        chk("b_state_resp", 32'(arb_state), 32'(2'b10));
        chk("b_gnt_snoop", 32'(gnt_snoop), 32'(4'b0001));
        req_proc  = 4'b0000;
        req_snoop = 4'b0000;
        #1;
        chk("b_drop_comb", 32'({gnt_proc, gnt_snoop, gnt_lv2}), 32'(0));
        cyc();
        chk("b_state_idle", 32'(arb_state), 32'(2'b00));
        req_proc = 4'b0100;
        #1;
        chk("b_bubble_gnt", 32'(gnt_proc), 32'(0));
        cyc();
        chk("b_regrant", 32'(gnt_proc), 32'(4'b0100));
        chk("b_state_proc", 32'(arb_state), 32'(2'b01));

        // Async reset mid-RESP; sticky timeout must survive until then.
        req_snoop = 4'b0010;
        cyc();
        chk("c_state_resp", 32'(arb_state), 32'(2'b10));
        chk("c_gnt_snoop", 32'(gnt_snoop), 32'(4'b0010));
        chk("c_timeout_sticky", 32'(arb_timeout), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("c_rst_gnt_proc", 32'(gnt_proc), 32'(0));
        chk("c_rst_gnt_snoop", 32'(gnt_snoop), 32'(0));
        chk("c_rst_state", 32'(arb_state), 32'(0));
        chk("c_rst_timeout", 32'(arb_timeout), 32'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        req_snoop = 4'b0000;
        cyc();
        chk("c_post_rst_gnt", 32'(gnt_proc), 32'(4'b0100));
        chk("c_post_rst_state", 32'(arb_state), 32'(2'b01));
        req_proc = 4'b0000;
        cyc();
        chk("c_idle", 32'(arb_state), 32'(2'b00));

        // Proc winner selection after core1 tenure (pointer at 2 in RR build).
        tenure(4'b0010, 4'b0010, "d_core1");
`ifdef LV1_LV2_ARB_ROUND_ROBIN_EN
        tenure(4'b0110, 4'b0100, "d_pick_0110");
`else
        tenure(4'b0110, 4'b0010, "d_pick_0110");
`endif
        tenure(4'b0010, 4'b0010, "d_core1b");
        tenure(4'b0011, 4'b0001, "d_pick_0011");

        // Watchdog: fires on the 8th tenure cycle, sticky after drop.
        req_proc = 4'b0001;
        cyc();
        chk("e_state_proc", 32'(arb_state), 32'(2'b01));
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk($sformatf("e_timeout_c%0d", i), 32'(arb_timeout), 32'(i == 8));
        end
        chk("e_gnt_unaffected", 32'(gnt_proc), 32'(4'b0001));
        req_proc = 4'b0000;
        repeat (3) cyc();
        chk("e_state_idle", 32'(arb_state), 32'(2'b00));
        chk("e_timeout_held", 32'(arb_timeout), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("e_timeout_cleared", 32'(arb_timeout), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
